// File: rtl/fetch_buf_if.sv
// fetch_buf_if: icache request/response channel plus the instruction queue output port.
interface fetch_buf_if #(
  parameter int ADDR_W = 36,
  parameter int INSTR_W = 32
);
  logic icache_req;
  logic [ADDR_W-1:0] icache_addr;
  logic icache_gnt;
  logic icache_rvalid;
  logic [INSTR_W-1:0] icache_rdata;
  logic out_valid;
  logic out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  modport master (
    output icache_req, icache_addr, out_valid, out_instr, out_pc,
    input icache_gnt, icache_rvalid, icache_rdata, out_ready
  );
  modport slave (
    input icache_req, icache_addr, out_valid, out_instr, out_pc,
    output icache_gnt, icache_rvalid, icache_rdata, out_ready
  );
endinterface

// File: rtl/fetch_buf.sv
// fetch_buf: single-outstanding instruction fetcher feeding a DEPTH-entry queue.
// Optional vector register decode of the queue head is enabled by FETCH_VREG_DECODE_EN.
module fetch_buf #(
  parameter int ADDR_W = 36,
  parameter int INSTR_W = 32,
  parameter int DEPTH = 4,
  parameter int PC_STEP = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic halt,
  input  logic unhalt,
  output logic is_running,
  fetch_buf_if.master bus,
  output logic [4:0] vread1,
  output logic [4:0] vread2
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [ADDR_W-1:0] fetch_pc, req_pc;
  logic outstanding, stale, halted;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [ADDR_W-1:0] q_pc [DEPTH];
  logic [INSTR_W-1:0] q_instr [DEPTH];
  logic grant, push, pop;
  assign is_running = ~halted;
  // count < DEPTH with one request in flight guarantees the response has a free slot
  assign bus.icache_req = rst_n & ~halted & ~redirect & ~outstanding & (count < CW'(DEPTH));
  assign bus.icache_addr = fetch_pc;
  assign grant = bus.icache_req & bus.icache_gnt;
  assign push = outstanding & ~stale & bus.icache_rvalid;
  assign pop = bus.out_valid & bus.out_ready;
  assign bus.out_valid = count != '0;
  assign bus.out_pc = q_pc[rd_ptr];
  assign bus.out_instr = q_instr[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      req_pc <= '0;
      outstanding <= 1'b0;
      stale <= 1'b0;
      halted <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      halted <= halted ? ~unhalt : halt;
      if (redirect) begin
        fetch_pc <= redirect_pc;
        outstanding <= outstanding & ~bus.icache_rvalid;
        stale <= outstanding & ~bus.icache_rvalid;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
      end else begin
        if (grant) begin
          fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
          req_pc <= fetch_pc;
          outstanding <= 1'b1;
          stale <= 1'b0;
        end else if (bus.icache_rvalid) begin
          outstanding <= 1'b0;
          stale <= 1'b0;
        end
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  always_ff @(posedge clk)
    if (push) begin
      q_pc[wr_ptr] <= req_pc;
      q_instr[wr_ptr] <= bus.icache_rdata;
    end
`ifdef FETCH_VREG_DECODE_EN
  logic [6:0] op;
  assign op = bus.out_instr[31:25];
  assign vread1 = (op == 7'b0100100 || op == 7'b0101101 || op == 7'b0110110 || op == 7'b0010010)
                  ? bus.out_instr[9:5] : bus.out_instr[19:15];
  assign vread2 = bus.out_instr[14:10];
`else
  assign vread1 = '0;
  assign vread2 = '0;
`endif
endmodule

// File: tb/tb_fetch_buf.sv
// tb_fetch_buf: directed scoreboard bench for fetch_buf with a behavioural icache model.
module tb_fetch_buf;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic redirect = 1'b0, halt = 1'b0, unhalt = 1'b0;
  logic [35:0] redirect_pc = '0;
  logic is_running;
  logic [4:0] vread1, vread2;
  logic gnt = 1'b0, out_ready = 1'b0, inj = 1'b0;
  logic ovr_en = 1'b0;
  logic [31:0] ovr = '0;
  int lat = 1;
  int gcnt = 0;
  int cyc = 0;
  int checks = 0, errors = 0;
  logic gap_en = 1'b0;
  int last_pop = -1;
  logic [67:0] exp_q [$];
  logic [1:0] wt;
  logic model_rv;
  logic [31:0] model_rd;
  logic redirect8 = 1'b0, rec8 = 1'b0, run8, rv8;
  logic [7:0] pc8 = '0;
  logic [4:0] v81, v82;
  logic [7:0] g8 [$];

  fetch_buf_if #(.ADDR_W(36), .INSTR_W(32)) bus ();
  fetch_buf_if #(.ADDR_W(8), .INSTR_W(32)) bus8 ();

  fetch_buf #(.ADDR_W(36), .INSTR_W(32), .DEPTH(4), .PC_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .unhalt(unhalt), .is_running(is_running), .bus(bus),
    .vread1(vread1), .vread2(vread2)
  );
  fetch_buf #(.ADDR_W(8), .INSTR_W(32), .DEPTH(4), .PC_STEP(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .redirect(redirect8), .redirect_pc(pc8),
    .halt(1'b0), .unhalt(1'b0), .is_running(run8), .bus(bus8),
    .vread1(v81), .vread2(v82)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] instr_of(input logic [35:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pc(input logic [35:0] pc);
    exp_q.push_back({pc, instr_of(pc)});
  endtask

  // icache model: response arrives lat cycles after the grant edge
  assign bus.icache_gnt = gnt;
  assign bus.icache_rvalid = model_rv | inj;
  assign bus.icache_rdata = model_rd;
  assign bus.out_ready = out_ready;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wt <= '0;
      model_rv <= 1'b0;
    end else begin
      model_rv <= 1'b0;
      if (bus.icache_req && bus.icache_gnt) begin
        gcnt <= gcnt + 1;
        model_rd <= ovr_en ? ovr : instr_of(bus.icache_addr);
        if (lat == 1) model_rv <= 1'b1;
        else wt <= 2'(lat - 1);
      end else if (wt != 0) begin
        wt <= wt - 2'd1;
        if (wt == 2'd1) model_rv <= 1'b1;
      end
    end

  assign bus8.icache_gnt = 1'b1;
  assign bus8.icache_rvalid = rv8;
  assign bus8.icache_rdata = '0;
  assign bus8.out_ready = 1'b1;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) rv8 <= 1'b0;
    else begin
      rv8 <= bus8.icache_req & bus8.icache_gnt;
      if (rec8 && bus8.icache_req && bus8.icache_gnt) g8.push_back(bus8.icache_addr);
    end

  // monitor: every accepted head is compared against the scoreboard queue
  always @(negedge clk) begin
    if (!gap_en) last_pop = -1;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop actual=%h required=none", {bus.out_pc, bus.out_instr});
      end else chk("pop_entry", {bus.out_pc, bus.out_instr}, exp_q.pop_front());
      if (gap_en) begin
        if (last_pop >= 0) chk("pop_gap", 68'(cyc - last_pop), 68'd2);
        last_pop = cyc;
      end
    end
  end

  initial begin
    int gbase;
    logic [4:0] e1a, e2a, e1b, e2b;
    step(3);
    chk("rst_req", bus.icache_req, 1'b0);
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_running", is_running, 1'b1);
    // release reset with a spurious rvalid in the first cycle
    rst_n = 1'b1;
    inj = 1'b1;
    step(1);
    inj = 1'b0;
    chk("post_rst_rvalid_ignored", bus.out_valid, 1'b0);
    chk("post_rst_req", bus.icache_req, 1'b1);
    chk("post_rst_addr", bus.icache_addr, 36'h0);
    // free-running: one instruction every two cycles
    expect_pc(36'h0); expect_pc(36'h4); expect_pc(36'h8);
    gap_en = 1'b1;
    gnt = 1'b1;
    out_ready = 1'b1;
    step(6);
    gnt = 1'b0;
    step(4);
    chk("stream_drained", 68'(exp_q.size()), 68'd0);
    chk("stream_empty", bus.out_valid, 1'b0);
    gap_en = 1'b0;
    out_ready = 1'b0;
    // backpressure: fill to DEPTH, then one pop admits exactly one request
    gbase = gcnt;
    gnt = 1'b1;
    step(12);
    chk("full_grants", 68'(gcnt - gbase), 68'd4);
    chk("full_req", bus.icache_req, 1'b0);
    chk("full_count", 68'(dut.count), 68'd4);
    expect_pc(36'hC); expect_pc(36'h10); expect_pc(36'h14); expect_pc(36'h18); expect_pc(36'h1C);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    step(6);
    chk("refill_grants", 68'(gcnt - gbase), 68'd5);
    chk("refill_count", 68'(dut.count), 68'd4);
    chk("refill_req", bus.icache_req, 1'b0);
    gnt = 1'b0;
    out_ready = 1'b1;
    step(6);
    chk("full_drained", 68'(exp_q.size()), 68'd0);
    // redirect with a request outstanding: late response must be dropped
    lat = 2;
    gnt = 1'b1;
    step(1);
    gnt = 1'b0;
    redirect = 1'b1;
    redirect_pc = 36'h100;
    chk("redir_req_block", bus.icache_req, 1'b0);
    step(1);
    redirect = 1'b0;
    chk("redir_outstanding", bus.icache_req, 1'b0);
    step(1);
    chk("redir_drop", bus.out_valid, 1'b0);
    chk("redir_req", bus.icache_req, 1'b1);
    chk("redir_addr", bus.icache_addr, 36'h100);
    // redirect coincident with rvalid also drops the response
    lat = 1;
    gnt = 1'b1;
    step(1);
    gnt = 1'b0;
    redirect = 1'b1;
    redirect_pc = 36'h200;
    step(1);
    redirect = 1'b0;
    chk("redir_same_drop", bus.out_valid, 1'b0);
    chk("redir_same_addr", bus.icache_addr, 36'h200);
    out_ready = 1'b0;
    // halt with a request in flight: response still lands, no new requests
    expect_pc(36'h200);
    gnt = 1'b1;
    step(1);
    halt = 1'b1;
    step(1);
    halt = 1'b0;
    gbase = gcnt;
    chk("halt_running", is_running, 1'b0);
    chk("halt_enqueued", bus.out_valid, 1'b1);
    step(4);
    chk("halt_no_req", bus.icache_req, 1'b0);
    chk("halt_no_grant", 68'(gcnt - gbase), 68'd0);
    gnt = 1'b0;
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    chk("halt_drain", bus.out_valid, 1'b0);
    chk("halt_sb_empty", 68'(exp_q.size()), 68'd0);
    unhalt = 1'b1;
    step(1);
    unhalt = 1'b0;
    chk("unhalt_running", is_running, 1'b1);
    chk("unhalt_req", bus.icache_req, 1'b1);
    chk("unhalt_addr", bus.icache_addr, 36'h204);
    halt = 1'b1;
    unhalt = 1'b1;
    step(1);
    halt = 1'b0;
    unhalt = 1'b0;
    chk("toggle_halted", is_running, 1'b0);
    redirect = 1'b1;
    redirect_pc = 36'h300;
    step(1);
    redirect = 1'b0;
    chk("halt_redir_running", is_running, 1'b0);
    chk("halt_redir_req", bus.icache_req, 1'b0);
    unhalt = 1'b1;
    step(1);
    unhalt = 1'b0;
    chk("halt_redir_addr", bus.icache_addr, 36'h300);
    chk("halt_redir_resume", bus.icache_req, 1'b1);
    // reset mid-transaction
    lat = 2;
    gnt = 1'b1;
    step(1);
    rst_n = 1'b0;
    gnt = 1'b0;
    #1;
    chk("midrst_req", bus.icache_req, 1'b0);
    chk("midrst_valid", bus.out_valid, 1'b0);
    step(2);
    rst_n = 1'b1;
    lat = 1;
    #1;
    chk("midrst_pc", bus.icache_addr, 36'h0);
    step(3);
    chk("midrst_no_push", bus.out_valid, 1'b0);
    // vector register decode of the queue head
`ifdef FETCH_VREG_DECODE_EN
    e1a = 5'd3; e2a = 5'd9; e1b = 5'd7; e2b = 5'd9;
`else
    e1a = 5'd0; e2a = 5'd0; e1b = 5'd0; e2b = 5'd0;
`endif
    ovr_en = 1'b1;
    ovr = {7'b0100100, 5'd0, 5'd7, 5'd9, 5'd3, 5'd0};
    gnt = 1'b1;
    step(1);
    gnt = 1'b0;
    step(1);
    chk("vdec_head_valid", bus.out_valid, 1'b1);
    chk("vdec_hit_v1", vread1, e1a);
    chk("vdec_hit_v2", vread2, e2a);
    redirect = 1'b1;
    redirect_pc = 36'h400;
    step(1);
    redirect = 1'b0;
    ovr = {7'b1111111, 5'd0, 5'd7, 5'd9, 5'd3, 5'd0};
    gnt = 1'b1;
    step(1);
    gnt = 1'b0;
    step(1);
    chk("vdec_miss_v1", vread1, e1b);
    chk("vdec_miss_v2", vread2, e2b);
    ovr_en = 1'b0;
    // narrow address wrap on the 8-bit instance
    redirect8 = 1'b1;
    pc8 = 8'hFC;
    step(1);
    redirect8 = 1'b0;
    rec8 = 1'b1;
    step(6);
    chk("wrap_grants", 68'(g8.size() >= 2), 68'd1);
    if (g8.size() >= 2) begin
      chk("wrap_first", g8[0], 8'hFC);
      chk("wrap_second", g8[1], 8'h00);
    end
    chk("final_sb_empty", 68'(exp_q.size()), 68'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_buf.md
FETCH_BUF -- requirements
Module: fetch_buf

Interface
REQ-001 SHALL have parameter ADDR_W, default 36: width of every PC/address.
REQ-002 SHALL have parameter INSTR_W, default 32: instruction width.
REQ-003 SHALL have parameter DEPTH, default 4: instruction queue entries; legal values are powers of two, 2 or more.
REQ-004 SHALL have parameter PC_STEP, default 4: sequential PC increment.
REQ-005 SHALL have parameter RESET_PC, default 0: PC value loaded on reset.
REQ-006 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-007 Ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- redirect  in  1  branch/flush request.
- redirect_pc  in  ADDR_W  target PC for a redirect.
- halt  in  1  stop fetching.
- unhalt  in  1  resume fetching.
- is_running  out  1  high when the core is not halted.
- icache_req  out  1  fetch request valid.
- icache_addr  out  ADDR_W  fetch address.
- icache_gnt  in  1  request accepted this cycle.
- icache_rvalid  in  1  response valid.
- icache_rdata  in  INSTR_W  response instruction.
- out_valid  out  1  queue head valid.
- out_ready  in  1  consumer accepts the head.
- out_instr  out  INSTR_W  head instruction.
- out_pc  out  ADDR_W  head PC.
- vread1  out  5  vector read register 1.
- vread2  out  5  vector read register 2.

Function
REQ-008 fetch_pc SHALL advance by PC_STEP, modulo 2^ADDR_W, on every granted request; wrap-around is silent.
REQ-009 icache_req SHALL be asserted only when all of the following hold:
- is_running is high;
- redirect is low;
- no request is outstanding;
- count is below DEPTH.
REQ-010 icache_addr SHALL equal fetch_pc whenever icache_req is high.
REQ-011 At most one request SHALL be outstanding; it opens on req&gnt and closes on icache_rvalid.
REQ-012 A non-stale response SHALL push {fetch address, icache_rdata} into the queue; out_valid rises the cycle after rvalid; there is no bypass.
REQ-013 out_valid SHALL equal (count != 0); a pop occurs on out_valid&out_ready; simultaneous push and pop leaves count unchanged.
REQ-014 Queue pointers SHALL wrap modulo DEPTH; count width is clog2(DEPTH+1); the credit rule in REQ-009 guarantees that a push never targets a full queue.
REQ-015 Redirect SHALL have highest priority and acts at the next edge:
- queue is flushed (count to 0);
- fetch_pc is set to redirect_pc;
- any outstanding request is marked stale.
REQ-016 A stale response SHALL be discarded without a push; it clears the outstanding flag. A redirect in the same cycle as rvalid discards that response.
REQ-017 Halt state SHALL update as next = (halted & ~unhalt) | (~halted & halt); halt and unhalt asserted together toggle the state.
REQ-018 While halted, a new request SHALL NOT issue. An outstanding response still completes and pushes, and the queue still drains.
REQ-019 A redirect while halted SHALL update fetch_pc and flush the queue, but SHALL NOT unhalt.
REQ-020 Steady-state throughput SHALL be one instruction per two cycles with a 1-cycle cache; it is not a pipelined fetch.

Reset
REQ-021 While rst_n is low, the block SHALL hold:
- fetch_pc = RESET_PC;
- count, read/write pointers = 0;
- outstanding = 0, stale = 0;
- halted = 0, so is_running = 1;
- icache_req = 0, out_valid = 0.
REQ-022 Reset asserted mid-transaction SHALL abandon the outstanding request; an rvalid in the first cycle after reset SHALL be ignored.

Configuration
REQ-023 Macro FETCH_VREG_DECODE_EN SHALL control vector register decode of out_instr.
REQ-024 With FETCH_VREG_DECODE_EN defined, decode SHALL be as follows:
- vread1 = out_instr[9:5] when opcode out_instr[31:25] is one of 7'b0100100, 7'b0101101, 7'b0110110, 7'b0010010;
- otherwise vread1 = out_instr[19:15];
- vread2 = out_instr[14:10].
REQ-025 With FETCH_VREG_DECODE_EN undefined, vread1 and vread2 SHALL be tied to 0 and no decode logic is built.

Verification
REQ-026 Reset then free-running: gnt=1, rvalid 1 cycle later, out_ready=1 -> out_pc = 0x0, 0x4, 0x8, one every 2 cycles.
REQ-027 out_ready=0, DEPTH=4 -> exactly 4 pushes, then icache_req stays 0 and count=4; after one pop, exactly one new request issues.
REQ-028 Redirect to 0x100 while a request is outstanding -> the following rvalid is dropped, the queue is empty, and the next icache_addr=0x100.
REQ-029 Halt pulse with a request outstanding -> the response is enqueued, no further icache_req, is_running=0; unhalt pulse -> requests resume at the next PC.
REQ-030 ADDR_W=8, redirect_pc=0xFC -> fetch addresses 0xFC, then 0x00 (wrap).
REQ-031 With FETCH_VREG_DECODE_EN, head opcode 7'b0100100, [9:5]=3, [19:15]=7, [14:10]=9 -> vread1=3, vread2=9. With any other opcode -> vread1=7.
